// File: rtl/intr_scheduler_pkg.sv
// Shared definitions for the PicoBlaze interrupt scheduler: default port
// addresses next to the rest of the I/O map, and the handshake FSM encoding.
package intr_scheduler_pkg;

    localparam int         NUM_SRC_DEF  = 4;

    localparam logic [7:0] PA_CAUSE_DEF = 8'h08;
    localparam logic [7:0] PA_MASK_DEF  = 8'h18;
    localparam logic [7:0] PA_PEND_DEF  = 8'h28;
    localparam logic [7:0] PA_OVR_DEF   = 8'h38;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } sched_state_e;

    // Byte lane mask covering the implemented source bits.
    function automatic logic [7:0] src_valid_mask(input int n);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/intr_scheduler_if.sv
// PicoBlaze port bus plus interrupt handshake as seen by the scheduler.
interface intr_scheduler_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] io_data_in;
    logic [7:0] io_data_out;
    logic       rd_hit;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, read_strobe, io_data_in, interrupt_ack,
        input  io_data_out, rd_hit, interrupt
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, io_data_in, interrupt_ack,
        output io_data_out, rd_hit, interrupt
    );
endinterface

// File: rtl/intr_scheduler_prio_enc_onehot.sv
// Fixed-priority select: one-hot of the lowest set request bit, plus an any flag.
module prio_enc_onehot #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] onehot_o,
    output logic         any_o
);

    // Scan from the top so the lowest index is the last one written.
    always_comb begin
        onehot_o = {N{1'b0}};
        any_o    = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                onehot_o    = {N{1'b0}};
                onehot_o[i] = 1'b1;
            end else begin
                onehot_o = onehot_o;
            end
        end
    end

endmodule

// File: rtl/intr_scheduler.sv
// Interrupt scheduler for the KCPSM6: latches source edges as pending,
// arbitrates by fixed priority and runs the interrupt/ack/EOI handshake.
module intr_scheduler
    import intr_scheduler_pkg::*;
#(
    parameter int         NUM_SRC  = NUM_SRC_DEF,
    parameter logic [7:0] PA_CAUSE = PA_CAUSE_DEF,
    parameter logic [7:0] PA_MASK  = PA_MASK_DEF,
    parameter logic [7:0] PA_PEND  = PA_PEND_DEF,
    parameter logic [7:0] PA_OVR   = PA_OVR_DEF
) (
    input  logic               sysclk,
    input  logic               sysreset,
    input  logic [NUM_SRC-1:0] src_in,
    intr_scheduler_if.slave    bus
);

    localparam logic [7:0] SRC_VALID = src_valid_mask(NUM_SRC);

    sched_state_e state_q, state_d;

    logic [NUM_SRC-1:0] src_prev_q;
    logic [7:0]         pending_q, pending_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         overrun_q, overrun_d;
    logic [7:0]         cause_q, cause_d;
    logic               irq_q, irq_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rd_hit_q, rd_hit_d;

    logic [7:0]         evt_s;
    logic [7:0]         ack_clr_s;
    logic [7:0]         ovr_wclr_s;
    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] win_s;
    logic               any_s;
    logic               wr_cause_s;
    logic               wr_mask_s;
    logic               wr_ovr_s;

    // Edge detect and bus write decode
    always_comb begin
        evt_s      = 8'(src_in & ~src_prev_q);
        wr_cause_s = bus.write_strobe && (bus.port_id == PA_CAUSE);
        wr_mask_s  = bus.write_strobe && (bus.port_id == PA_MASK);
        wr_ovr_s   = bus.write_strobe && (bus.port_id == PA_OVR);
        req_s      = pending_q[NUM_SRC-1:0] & mask_q[NUM_SRC-1:0];
    end

    prio_enc_onehot #(
        .N (NUM_SRC)
    ) u_prio (
        .req_i    (req_s),
        .onehot_o (win_s),
        .any_o    (any_s)
    );

    // Handshake FSM: next state, cause latch, interrupt line, pending clear on ack
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        irq_d     = irq_q;
        ack_clr_s = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d = ST_ASSERT;
                    cause_d = 8'(win_s);
                    irq_d   = 1'b1;
                end else begin
                    irq_d   = 1'b0;
                end
            end
            ST_ASSERT: begin
                // Masking the cause here deliberately does not withdraw the request.
                if (bus.interrupt_ack) begin
                    state_d   = ST_SERVICE;
                    irq_d     = 1'b0;
                    ack_clr_s = cause_q;
                end else begin
                    irq_d     = 1'b1;
                end
            end
            ST_SERVICE: begin
                irq_d = 1'b0;
                if (wr_cause_s) begin
                    state_d = ST_IDLE;
                    cause_d = 8'h00;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cause_d = 8'h00;
                irq_d   = 1'b0;
            end
        endcase
    end

    // Pending / overrun / mask next-state; a fresh event on the acked source re-arms it
    always_comb begin
        if (wr_ovr_s) begin
            ovr_wclr_s = bus.io_data_in;
        end else begin
            ovr_wclr_s = 8'h00;
        end
        if (wr_mask_s) begin
            mask_d = bus.io_data_in & SRC_VALID;
        end else begin
            mask_d = mask_q;
        end
        pending_d = ((pending_q & ~ack_clr_s) | evt_s) & SRC_VALID;
        overrun_d = ((overrun_q & ~ovr_wclr_s) | (pending_q & evt_s & ~ack_clr_s)) & SRC_VALID;
    end

    // Read-data mux, registered every cycle from port_id
    always_comb begin
        rdata_d  = 8'h00;
        rd_hit_d = 1'b0;
        if (bus.port_id == PA_CAUSE) begin
            rdata_d  = cause_q;
            rd_hit_d = 1'b1;
        end else if (bus.port_id == PA_MASK) begin
            rdata_d  = mask_q;
            rd_hit_d = 1'b1;
        end else if (bus.port_id == PA_PEND) begin
            rdata_d  = pending_q;
            rd_hit_d = 1'b1;
        end else if (bus.port_id == PA_OVR) begin
            rdata_d  = overrun_q;
            rd_hit_d = 1'b1;
        end else begin
            rdata_d  = 8'h00;
            rd_hit_d = 1'b0;
        end
    end

    // All state; events arriving during reset are dropped with the history
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            state_q    <= ST_IDLE;
            src_prev_q <= {NUM_SRC{1'b0}};
            pending_q  <= 8'h00;
            mask_q     <= 8'h00;
            overrun_q  <= 8'h00;
            cause_q    <= 8'h00;
            irq_q      <= 1'b0;
            rdata_q    <= 8'h00;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_prev_q <= src_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            overrun_q  <= overrun_d;
            cause_q    <= cause_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    assign bus.interrupt   = irq_q;
    assign bus.io_data_out = rdata_q;
    assign bus.rd_hit      = rd_hit_q;

endmodule

// File: tb/tb_intr_scheduler.sv
// Self-checking bench for intr_scheduler: expected causes are queued when
// sources are pulsed and popped when the cause register is read back.
module tb_intr_scheduler;

    localparam int         NSRC     = 4;
    localparam logic [7:0] A_CAUSE  = 8'h08;
    localparam logic [7:0] A_MASK   = 8'h18;
    localparam logic [7:0] A_PEND   = 8'h28;
    localparam logic [7:0] A_OVR    = 8'h38;

    logic            clk;
    logic            rst_n;
    logic [NSRC-1:0] src;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    intr_scheduler_if bus_if();

    intr_scheduler #(.NUM_SRC(NSRC)) dut (
        .sysclk   (clk),
        .sysreset (rst_n),
        .src_in   (src),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus_if.port_id      = addr;
        bus_if.io_data_in   = data;
        bus_if.write_strobe = 1'b1;
        tick();
        bus_if.write_strobe = 1'b0;
        bus_if.port_id      = 8'h00;
        bus_if.io_data_in   = 8'h00;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] data, output logic hit);
        bus_if.read_strobe = 1'b1;
        bus_if.port_id     = addr;
        tick();
        data               = bus_if.io_data_out;
        hit                = bus_if.rd_hit;
        bus_if.read_strobe = 1'b0;
        bus_if.port_id     = 8'h00;
    endtask

    task automatic rd_expect(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic       h;
        rd(addr, d, h);
        if ({h, d} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL %s: got hit=%0b data=0x%02h, want hit=1 data=0x%02h", name, h, d, exp);
        end
        checks++;
    endtask

    task automatic pulse(input logic [NSRC-1:0] bits);
        src = src | bits;
        tick();
        src = src & ~bits;
        tick();
    endtask

    task automatic wait_irq(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus_if.interrupt === 1'b1) break;
            tick();
        end
        if (bus_if.interrupt !== 1'b1) begin
            errors++;
            $display("FAIL %s: interrupt=%0b after %0d cycles, want 1", name, bus_if.interrupt, budget);
        end
        checks++;
    endtask

    task automatic do_ack(input string name);
        bus_if.interrupt_ack = 1'b1;
        tick();
        bus_if.interrupt_ack = 1'b0;
        if (bus_if.interrupt !== 1'b0) begin
            errors++;
            $display("FAIL %s: interrupt=%0b after ack, want 0", name, bus_if.interrupt);
        end
        checks++;
    endtask

    task automatic check_cause(input string name);
        logic [7:0] d;
        logic       h;
        logic [7:0] exp;
        rd(A_CAUSE, d, h);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: cause 0x%02h read with empty scoreboard", name, d);
        end else begin
            exp = exp_q.pop_front();
            if ({h, d} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL %s: got hit=%0b cause=0x%02h, want hit=1 cause=0x%02h", name, h, d, exp);
            end
        end
        checks++;
    endtask

    task automatic check_irq(input string name, input logic exp);
        if (bus_if.interrupt !== exp) begin
            errors++;
            $display("FAIL %s: interrupt=%0b, want %0b", name, bus_if.interrupt, exp);
        end
        checks++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.port_id = A_MASK;
        tick();
        tick();
        if ({bus_if.interrupt, bus_if.rd_hit, bus_if.io_data_out} !== 10'h000) begin
            errors++;
            $display("FAIL reset_outputs: irq=%0b hit=%0b data=0x%02h, want 0 0 0x00",
                     bus_if.interrupt, bus_if.rd_hit, bus_if.io_data_out);
        end
        checks++;
        rst_n = 1'b1;
        bus_if.port_id = 8'h00;
        tick();
        rd_expect("reset_mask", A_MASK, 8'h00);
        rd_expect("reset_pend", A_PEND, 8'h00);
        rd_expect("reset_ovr", A_OVR, 8'h00);
        rd_expect("reset_cause", A_CAUSE, 8'h00);
    endtask

    task automatic test_single();
        wr(A_MASK, 8'h01);
        rd_expect("single_mask", A_MASK, 8'h01);
        exp_q.push_back(8'h01);
        src[0] = 1'b1;
        tick();
        check_irq("single_irq_1cyc", 1'b0);
        src[0] = 1'b0;
        tick();
        check_irq("single_irq_2cyc", 1'b1);
        do_ack("single_ack");
        check_cause("single_cause");
        rd_expect("single_pend", A_PEND, 8'h00);
        wr(A_CAUSE, 8'h00);
        rd_expect("single_cause_after_eoi", A_CAUSE, 8'h00);
    endtask

    task automatic test_masked();
        wr(A_MASK, 8'h00);
        pulse(4'b0100);
        tick();
        check_irq("masked_no_irq", 1'b0);
        rd_expect("masked_pend", A_PEND, 8'h04);
        exp_q.push_back(8'h04);
        wr(A_MASK, 8'hF4);
        rd_expect("mask_upper_bits", A_MASK, 8'h04);
        wait_irq("masked_enable_irq", 2);
        do_ack("masked_ack");
        check_cause("masked_cause");
        wr(A_CAUSE, 8'h00);
    endtask

    task automatic test_back_to_back();
        wr(A_MASK, 8'h0F);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h08);
        pulse(4'b1010);
        wait_irq("b2b_first_irq", 3);
        do_ack("b2b_first_ack");
        for (int i = 0; i < 3; i++) begin
            check_irq("b2b_service_quiet", 1'b0);
            tick();
        end
        check_cause("b2b_first_cause");
        wr(A_CAUSE, 8'h00);
        check_irq("b2b_eoi_cycle", 1'b0);
        tick();
        check_irq("b2b_second_irq", 1'b1);
        do_ack("b2b_second_ack");
        check_cause("b2b_second_cause");
        wr(A_CAUSE, 8'h00);
        rd_expect("b2b_pend_empty", A_PEND, 8'h00);
    endtask

    task automatic test_overrun();
        wr(A_MASK, 8'h01);
        exp_q.push_back(8'h01);
        pulse(4'b0001);
        pulse(4'b0001);
        check_irq("ovr_irq_held", 1'b1);
        rd_expect("ovr_set", A_OVR, 8'h01);
        wr(A_OVR, 8'h01);
        rd_expect("ovr_cleared", A_OVR, 8'h00);
        do_ack("ovr_ack");
        check_cause("ovr_cause");
        wr(A_CAUSE, 8'h00);
        rd_expect("ovr_pend_after", A_PEND, 8'h00);

        // overrun set and write-clear in the same cycle: set wins
        exp_q.push_back(8'h01);
        pulse(4'b0001);
        wait_irq("ovr2_irq", 2);
        src[0] = 1'b1;
        bus_if.port_id      = A_OVR;
        bus_if.io_data_in   = 8'h01;
        bus_if.write_strobe = 1'b1;
        tick();
        src[0] = 1'b0;
        bus_if.write_strobe = 1'b0;
        bus_if.port_id      = 8'h00;
        bus_if.io_data_in   = 8'h00;
        tick();
        rd_expect("ovr_set_wins", A_OVR, 8'h01);
        wr(A_OVR, 8'h01);
        rd_expect("ovr_cleared2", A_OVR, 8'h00);

        // event on the cause in the ack cycle: stays pending, no overrun
        src[0] = 1'b1;
        bus_if.interrupt_ack = 1'b1;
        tick();
        src[0] = 1'b0;
        bus_if.interrupt_ack = 1'b0;
        check_irq("ackevt_irq_low", 1'b0);
        tick();
        rd_expect("ackevt_pend", A_PEND, 8'h01);
        rd_expect("ackevt_ovr", A_OVR, 8'h00);
        check_cause("ackevt_cause");
        exp_q.push_back(8'h01);
        wr(A_CAUSE, 8'h00);
        wait_irq("ackevt_reraise", 2);
        do_ack("ackevt_ack2");
        check_cause("ackevt_cause2");
        wr(A_CAUSE, 8'h00);
    endtask

    task automatic test_reset_midflight();
        logic [7:0] d;
        logic       h;
        pulse(4'b0001);
        wait_irq("rstmid_irq", 2);
        rst_n = 1'b0;
        bus_if.port_id = A_MASK;
        tick();
        if ({bus_if.interrupt, bus_if.rd_hit, bus_if.io_data_out} !== 10'h000) begin
            errors++;
            $display("FAIL rstmid_outputs: irq=%0b hit=%0b data=0x%02h, want 0 0 0x00",
                     bus_if.interrupt, bus_if.rd_hit, bus_if.io_data_out);
        end
        checks++;
        rst_n = 1'b1;
        bus_if.port_id = 8'h00;
        bus_if.interrupt_ack = 1'b1;
        tick();
        bus_if.interrupt_ack = 1'b0;
        wr(A_CAUSE, 8'h00);
        tick();
        check_irq("rstmid_no_reassert", 1'b0);
        rd_expect("rstmid_mask", A_MASK, 8'h00);
        rd_expect("rstmid_pend", A_PEND, 8'h00);
        rd_expect("rstmid_ovr", A_OVR, 8'h00);
        rd_expect("rstmid_cause", A_CAUSE, 8'h00);
        rd(8'h05, d, h);
        if ({h, d} !== 9'h000) begin
            errors++;
            $display("FAIL unmapped_read: got hit=%0b data=0x%02h, want hit=0 data=0x00", h, d);
        end
        checks++;
    endtask

    initial begin
        rst_n                = 1'b0;
        src                  = '0;
        bus_if.port_id       = 8'h00;
        bus_if.write_strobe  = 1'b0;
        bus_if.read_strobe   = 1'b0;
        bus_if.io_data_in    = 8'h00;
        bus_if.interrupt_ack = 1'b0;

        test_reset();
        test_single();
        test_masked();
        test_back_to_back();
        test_overrun();
        test_reset_midflight();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d causes never observed, want 0", exp_q.size());
        end
        checks++;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
